fpsm_core: RTL and testbench
============================

# fpsm_core

- Parametrised, reset-able successor of the FPSM 8-bit programmable state machine.
- Explicit multi-cycle FSM core with 4 general registers, Z/S/C flags, conditional jumps, load/store and HALT.
- Data width (DW) and address width (AW) are parameters.
- Sits between a synchronous single-port program/data RAM and the board display/debug logic.
- The clock divider is replaced by an `en` step strobe.

## Interface

Parameters:
- DW, 8: data/register width; DW ≥ 8; opcode is `mem_rdata[7:0]`.
- AW, 8: address width; 1 ≤ AW ≤ DW.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: step enable; FSM and all state advance only when high.
- mem_addr, output, AW: RAM address, combinational from state.
- mem_wdata, output, DW: RAM write data.
- mem_we, output, 1: RAM write strobe.
- mem_rdata, input, DW: RAM read data, valid one clk after `mem_addr` is presented.
- pc, output, AW: program counter.
- ir, output, 8: instruction register.
- flags, output, 3: {S,Z,C}.
- halted, output, 1: core is in HALT.
- dbg_sel, input, 2: debug register select.
- dbg_data, output, DW: R[dbg_sel], combinational.

## Operation

- Opcode fields: `ir[7:5]`=op, `rd=ir[3:2]`, `rs=ir[1:0]`.
- Instructions:
  - 000 MOV: rd←rs.
  - 001 ADD: rd←rd+rs; C=bit DW of the (DW+1)-bit sum.
  - 011 SUB: rd←rd−rs; C=1 iff rd<rs unsigned (borrow).
  - 100 MUL: rd←low DW bits of rd·rs; C unchanged.
  - 110 SHR: rd←rs>>1; C=rs[0].
  - 111 SHL: rd←rs<<1; C=rs[DW−1].
  - 101, ir[4]=0, LD: rd←mem[R[rs]].
  - 101, ir[4]=1, ST: mem[R[rd]]←R[rs].
  - 010 jump group: cond=`ir[4:3]`.
    - ir[2]=0: 00 JMP, 01 JC, 10 JZ, 11 JS. The next word is the target; low AW bits are used.
    - ir[2]=1 with cond=00: HLT.
    - ir[2]=1 with cond≠00: NOP, one byte.
- Flags:
  - Z=(result==0), S=result[DW−1].
  - Updated by MOV/ADD/SUB/MUL/SHR/SHL/LD only.
  - ST, jumps, NOP and HLT leave flags unchanged.
- Register/memory addresses use the low AW bits of the register.
- FSM states, advanced only on `en`:
  - FETCH: mem_addr=pc → DECODE.
  - DECODE: ir←mem_rdata[7:0]; pc←pc+1. Next state is decided from `mem_rdata`: jump→OPER; LD/ST→MEM; HLT→HALT; NOP→FETCH; else→EXEC.
  - EXEC: write rd and flags → FETCH.
  - OPER: mem_addr=pc → JUMP.
  - JUMP: cond true → pc←mem_rdata[AW−1:0]; false → pc←pc+1 (operand skipped). → FETCH.
  - MEM: mem_addr=R[ra]. For ST: mem_wdata=R[rs], mem_we=1 → FETCH. For LD → LDW.
  - LDW: rd←mem_rdata, flags updated → FETCH.
  - HALT: absorbing; only rst leaves it. `halted`=1.
- `mem_we = (state==MEM) & ST & en & !rst`. In every other state `mem_wdata` is don't-care and `mem_we`=0.
- `mem_addr` is pc in all states except MEM, where it is R[ra].
- PC arithmetic is modulo 2^AW; FF+1 wraps to 00 at AW=8.

## Timing

- Reset values: pc=0, ir=0, R0..R3=0, flags=000, state=FETCH, halted=0, mem_we=0, mem_addr=0.
- Cycle counts with en=1 throughout:

  | Instruction | Cycles |
  |---|---|
  | ALU ops | 3 |
  | NOP | 2 |
  | ST | 3 |
  | LD | 4 |
  | jump (taken or not) | 4 |
  | HLT | 2, then halted |

- en=0:
  - All registers, state and pc hold.
  - mem_we=0.
  - mem_addr stays stable.
  - The RAM read data must be re-presented by holding the address. The RAM returns the same data because mem_addr does not change.
- rst has priority over en and over any state. Asserting rst mid-instruction aborts the instruction with no register/flag writeback. A ST in progress performs no write in the rst cycle.
- Flag writes and rd writes for the same instruction occur on the same edge.
- Registered outputs (pc, ir, flags, halted) change only on clk edges.
- dbg_data is combinational from dbg_sel and the registers.

## Test plan

1. **Reset:** hold rst 2 cycles mid-program, then release → pc=00, ir=00, flags=000, mem_addr=00, mem_we never 1.
2. **Program, DW=8:** mem[00..05]=A4,25,48,05,00,44, en=1.
   - LD R1,[R0] → R1=A4, flags S=1 Z=0 C=0.
   - ADD R1,R1 → R1=48, C=1, S=0, Z=0.
   - JC 05 taken → pc=05.
   - HLT → halted=1 exactly 13 clocks after rst release; pc stays 06.
3. **SUB/ST:** R1=48, R2=00.
   - SUB R2,R1 (69) → R2=B8, C=1, S=1.
   - ST [R0],R1 (B1) → one cycle with mem_we=1, mem_addr=00, mem_wdata=48.
4. **en stall:** drop en for 5 cycles while in MEM of ST → mem_we=0 during stall, exactly one write pulse after en returns; final state identical to an unstalled run.
5. **Jump/wrap:**
   - JZ 40 (50,40) with Z=0 → pc=pc_of_JZ+2.
   - JMP FF (42,FF), mem[FF]=00 (MOV R0,R0) → after it pc wraps to 00, Z=1.
6. **DW=16, AW=10:**
   - ADD FFFF+0001 → result 0000, C=1, Z=1.
   - SHL of 8000 → 0000, C=1.
   - JMP operand 0x3C05 → pc=0x005 (low 10 bits).

Source files
------------

// File: rtl/fpsm_core.sv
// rtl/fpsm_core.sv - parametrised multi-cycle FPSM core with 4 registers, Z/S/C flags, load/store and HALT
// Steps one FSM state per clk while en is high; talks to a synchronous single-port RAM.
module fpsm_core #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW-1:0] pc,
  output logic [7:0]    ir,
  output logic [2:0]    flags,
  output logic          halted,
  input  logic [1:0]    dbg_sel,
  output logic [DW-1:0] dbg_data
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_OPER,
    S_JUMP,
    S_MEM,
    S_LDW,
    S_HALT
  } state_t;

  state_t        state, state_nx;
  logic [DW-1:0] regs [4];

  logic [AW-1:0] pc_nx;
  logic [7:0]    ir_nx;
  logic [2:0]    flags_nx;
  logic          rd_we;
  logic [DW-1:0] rd_val;

  logic [2:0]    op;
  logic [1:0]    rd_idx;
  logic [1:0]    rs_idx;
  logic [DW-1:0] rd_reg;
  logic [DW-1:0] rs_reg;
  logic [DW-1:0] ra_reg;
  logic          is_store;
  logic          cond_true;

  logic [DW-1:0] alu_res;
  logic          alu_c;

  assign op       = ir[7:5];
  assign rd_idx   = ir[3:2];
  assign rs_idx   = ir[1:0];
  assign rd_reg   = regs[rd_idx];
  assign rs_reg   = regs[rs_idx];
  assign is_store = ir[4];
  // ST addresses through rd, LD through rs
  assign ra_reg   = is_store ? rd_reg : rs_reg;

  assign dbg_data = regs[dbg_sel];
  assign halted   = (state == S_HALT);

  always_comb begin
    case (ir[4:3])
      2'b00:   cond_true = 1'b1;
      2'b01:   cond_true = flags[0];
      2'b10:   cond_true = flags[1];
      default: cond_true = flags[2];
    endcase
  end

  always_comb begin
    alu_res = rs_reg;
    alu_c   = flags[0];
    case (op)
      3'b000: alu_res = rs_reg;
      3'b001: {alu_c, alu_res} = {1'b0, rd_reg} + {1'b0, rs_reg};
      3'b011: begin
        alu_res = rd_reg - rs_reg;
        alu_c   = (rd_reg < rs_reg);
      end
      3'b100: alu_res = rd_reg * rs_reg;
      3'b110: begin
        alu_res = rs_reg >> 1;
        alu_c   = rs_reg[0];
      end
      3'b111: begin
        alu_res = rs_reg << 1;
        alu_c   = rs_reg[DW-1];
      end
      default: alu_res = rs_reg;
    endcase
  end

  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    ir_nx     = ir;
    flags_nx  = flags;
    rd_we     = 1'b0;
    rd_val    = alu_res;
    mem_addr  = pc;
    mem_wdata = rs_reg;
    mem_we    = 1'b0;
    case (state)
      S_FETCH: state_nx = S_DECODE;
      S_DECODE: begin
        ir_nx = mem_rdata[7:0];
        pc_nx = pc + AW'(1);
        // next state is decided from the fresh opcode, not the old ir
        case (mem_rdata[7:5])
          3'b010: begin
            if (!mem_rdata[2])
              state_nx = S_OPER;
            else if (mem_rdata[4:3] == 2'b00)
              state_nx = S_HALT;
            else
              state_nx = S_FETCH;
          end
          3'b101:  state_nx = S_MEM;
          default: state_nx = S_EXEC;
        endcase
      end
      S_EXEC: begin
        rd_we    = 1'b1;
        flags_nx = {alu_res[DW-1], (alu_res == '0), alu_c};
        state_nx = S_FETCH;
      end
      S_OPER: state_nx = S_JUMP;
      S_JUMP: begin
        pc_nx    = cond_true ? mem_rdata[AW-1:0] : pc + AW'(1);
        state_nx = S_FETCH;
      end
      S_MEM: begin
        mem_addr = ra_reg[AW-1:0];
        if (is_store) begin
          mem_we   = en & ~rst;
          state_nx = S_FETCH;
        end else begin
          state_nx = S_LDW;
        end
      end
      S_LDW: begin
        rd_we    = 1'b1;
        rd_val   = mem_rdata;
        flags_nx = {mem_rdata[DW-1], (mem_rdata == '0), flags[0]};
        state_nx = S_FETCH;
      end
      S_HALT: state_nx = S_HALT;
      default: state_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      pc    <= '0;
      ir    <= '0;
      flags <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (en) begin
      state <= state_nx;
      pc    <= pc_nx;
      ir    <= ir_nx;
      flags <= flags_nx;
      if (rd_we) regs[rd_idx] <= rd_val;
    end
  end

endmodule

// File: tb/tb_fpsm_core.sv
// tb/tb_fpsm_core.sv - scoreboard bench for fpsm_core at DW=8/AW=8 and DW=16/AW=10
// Stimulus pushes expected writes and halt snapshots; monitors pop and compare.
module tb_fpsm_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8 = 1'b1, en8 = 1'b1;
  logic [7:0] a8, wd8, rd8, pc8, ir8, dbg8;
  logic       we8, h8;
  logic [2:0] fl8;
  logic [1:0] sel8 = 2'd0;

  logic        rst16 = 1'b1, en16 = 1'b1;
  logic [9:0]  a16, pc16;
  logic [15:0] wd16, rd16, dbg16;
  logic [7:0]  ir16;
  logic        we16, h16;
  logic [2:0]  fl16;
  logic [1:0]  sel16 = 2'd0;

  fpsm_core #(.DW(8), .AW(8)) u8 (
    .clk(clk), .rst(rst8), .en(en8), .mem_addr(a8), .mem_wdata(wd8), .mem_we(we8),
    .mem_rdata(rd8), .pc(pc8), .ir(ir8), .flags(fl8), .halted(h8),
    .dbg_sel(sel8), .dbg_data(dbg8)
  );

  fpsm_core #(.DW(16), .AW(10)) u16 (
    .clk(clk), .rst(rst16), .en(en16), .mem_addr(a16), .mem_wdata(wd16), .mem_we(we16),
    .mem_rdata(rd16), .pc(pc16), .ir(ir16), .flags(fl16), .halted(h16),
    .dbg_sel(sel16), .dbg_data(dbg16)
  );

  logic [7:0]  mem8 [256];
  logic [7:0]  img8 [256];
  logic        ld8 = 1'b0;
  logic [15:0] mem16 [1024];
  logic [15:0] img16 [1024];
  logic        ld16 = 1'b0;

  always @(posedge clk) begin
    if (ld8) begin
      for (int i = 0; i < 256; i++) mem8[i] <= img8[i];
    end else if (we8) begin
      mem8[a8] <= wd8;
    end
    rd8 <= mem8[a8];
  end

  always @(posedge clk) begin
    if (ld16) begin
      for (int i = 0; i < 1024; i++) mem16[i] <= img16[i];
    end else if (we16) begin
      mem16[a16] <= wd16;
    end
    rd16 <= mem16[a16];
  end

  int cyc8 = 0, cyc16 = 0;
  always @(posedge clk) cyc8  <= rst8  ? 0 : cyc8 + 1;
  always @(posedge clk) cyc16 <= rst16 ? 0 : cyc16 + 1;

  typedef struct packed {
    logic             is_halt;
    logic [15:0]      addr;
    logic [15:0]      data;
    logic [15:0]      pc;
    logic [2:0]       fl;
    logic [3:0][15:0] r;
    logic [15:0]      cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic exp_t mk_write(logic [15:0] addr, logic [15:0] data);
    exp_t e;
    e = '0;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

  function automatic exp_t mk_halt(logic [15:0] pc, logic [2:0] fl, logic [15:0] r0,
                                   logic [15:0] r1, logic [15:0] r2, logic [15:0] r3,
                                   logic [15:0] cyc);
    exp_t e;
    e = '0;
    e.is_halt = 1'b1;
    e.pc = pc;
    e.fl = fl;
    e.r[0] = r0;
    e.r[1] = r1;
    e.r[2] = r2;
    e.r[3] = r3;
    e.cyc = cyc;
    return e;
  endfunction

  // monitor for the 8-bit core
  initial begin
    logic prev_h;
    exp_t e;
    prev_h = 1'b0;
    forever begin
      @(negedge clk);
      if (we8) begin
        if (q8.size() == 0 || q8[0].is_halt) begin
          chk("w8_unexpected_addr_data", {a8, wd8}, 32'hffff_ffff);
        end else begin
          e = q8.pop_front();
          chk("w8_addr", a8, e.addr);
          chk("w8_data", wd8, e.data);
        end
      end
      if (h8 && !prev_h) begin
        if (q8.size() == 0 || !q8[0].is_halt) begin
          chk("h8_unexpected_pc", pc8, 32'hffff_ffff);
        end else begin
          e = q8.pop_front();
          chk("h8_pc", pc8, e.pc);
          chk("h8_flags", fl8, e.fl);
          chk("h8_cycles", cyc8, e.cyc);
          for (int i = 0; i < 4; i++) begin
            sel8 = 2'(i);
            #1;
            chk($sformatf("h8_r%0d", i), dbg8, e.r[i]);
          end
        end
      end
      prev_h = h8;
    end
  end

  // monitor for the 16-bit core
  initial begin
    logic prev_h;
    exp_t e;
    prev_h = 1'b0;
    forever begin
      @(negedge clk);
      if (we16) begin
        if (q16.size() == 0 || q16[0].is_halt) begin
          chk("w16_unexpected_addr", a16, 32'hffff_ffff);
        end else begin
          e = q16.pop_front();
          chk("w16_addr", a16, e.addr);
          chk("w16_data", wd16, e.data);
        end
      end
      if (h16 && !prev_h) begin
        if (q16.size() == 0 || !q16[0].is_halt) begin
          chk("h16_unexpected_pc", pc16, 32'hffff_ffff);
        end else begin
          e = q16.pop_front();
          chk("h16_pc", pc16, e.pc);
          chk("h16_flags", fl16, e.fl);
          chk("h16_cycles", cyc16, e.cyc);
          for (int i = 0; i < 4; i++) begin
            sel16 = 2'(i);
            #1;
            chk($sformatf("h16_r%0d", i), dbg16, e.r[i]);
          end
        end
      end
      prev_h = h16;
    end
  end

  task automatic clear8();
    for (int i = 0; i < 256; i++) img8[i] = 8'h00;
  endtask

  task automatic clear16();
    for (int i = 0; i < 1024; i++) img16[i] = 16'h0000;
  endtask

  // load RAM image during a 2-cycle reset; releases rst just before cycle 1
  task automatic load_reset8();
    rst8 = 1'b1;
    en8  = 1'b1;
    ld8  = 1'b1;
    @(negedge clk);
    ld8 = 1'b0;
    @(negedge clk);
    rst8 = 1'b0;
  endtask

  task automatic load_reset16();
    rst16 = 1'b1;
    en16  = 1'b1;
    ld16  = 1'b1;
    @(negedge clk);
    ld16 = 1'b0;
    @(negedge clk);
    rst16 = 1'b0;
  endtask

  task automatic wait_halt8(string name, int budget);
    for (int i = 0; i < budget && !h8; i++) @(negedge clk);
    chk(name, h8, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_halt16(string name, int budget);
    for (int i = 0; i < budget && !h16; i++) @(negedge clk);
    chk(name, h16, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic img_p3();
    clear8();
    img8[0] = 8'hA4;
    img8[1] = 8'h25;
    img8[2] = 8'h69;
    img8[3] = 8'hB1;
    img8[4] = 8'h44;
  endtask

  initial begin
    // P1: LD R1,[R0]; NOP; HLT
    clear8();
    img8[0] = 8'hA4;
    img8[1] = 8'h4C;
    img8[2] = 8'h44;
    q8.push_back(mk_halt(16'h03, 3'b100, 16'h00, 16'hA4, 16'h00, 16'h00, 16'd8));
    load_reset8();
    wait_halt8("p1_halt_timeout", 100);

    // P2: LD, ADD, JC 05 (taken), HLT
    clear8();
    img8[0] = 8'hA4;
    img8[1] = 8'h25;
    img8[2] = 8'h48;
    img8[3] = 8'h05;
    img8[4] = 8'h00;
    img8[5] = 8'h44;
    q8.push_back(mk_halt(16'h06, 3'b001, 16'h00, 16'h48, 16'h00, 16'h00, 16'd13));
    load_reset8();
    wait_halt8("p2_halt_timeout", 100);

    // P3 aborted by reset while ST sits in MEM, then rerun from reset
    img_p3();
    load_reset8();
    repeat (11) @(negedge clk);
    @(posedge clk);
    #2 rst8 = 1'b1;
    @(negedge clk);
    chk("rst_mem_we_0", we8, 0);
    @(negedge clk);
    chk("rst_mem_we_1", we8, 0);
    chk("rst_pc", pc8, 0);
    chk("rst_ir", ir8, 0);
    chk("rst_flags", fl8, 0);
    chk("rst_mem_addr", a8, 0);
    chk("rst_halted", h8, 0);
    q8.push_back(mk_write(16'h00, 16'h48));
    q8.push_back(mk_halt(16'h05, 3'b101, 16'h00, 16'h48, 16'hB8, 16'h00, 16'd15));
    rst8 = 1'b0;
    wait_halt8("p3_rst_halt_timeout", 100);

    // P3 unstalled
    img_p3();
    q8.push_back(mk_write(16'h00, 16'h48));
    q8.push_back(mk_halt(16'h05, 3'b101, 16'h00, 16'h48, 16'hB8, 16'h00, 16'd15));
    load_reset8();
    wait_halt8("p3_halt_timeout", 100);

    // P3 with en low for 5 cycles while ST is in MEM
    img_p3();
    q8.push_back(mk_write(16'h00, 16'h48));
    q8.push_back(mk_halt(16'h05, 3'b101, 16'h00, 16'h48, 16'hB8, 16'h00, 16'd20));
    load_reset8();
    repeat (11) @(negedge clk);
    @(posedge clk);
    #2 en8 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall_we_%0d", i), we8, 0);
      chk($sformatf("stall_addr_%0d", i), a8, 0);
      @(posedge clk);
    end
    #2 en8 = 1'b1;
    wait_halt8("p3_stall_halt_timeout", 100);

    // P4: JZ not taken, JMP FF, MOV at FF wraps pc, JZ now taken to HLT at 40
    clear8();
    img8[8'h00] = 8'h50;
    img8[8'h01] = 8'h40;
    img8[8'h02] = 8'h42;
    img8[8'h03] = 8'hFF;
    img8[8'hFF] = 8'h00;
    img8[8'h40] = 8'h44;
    q8.push_back(mk_halt(16'h41, 3'b010, 16'h00, 16'h00, 16'h00, 16'h00, 16'd17));
    load_reset8();
    wait_halt8("p4_halt_timeout", 100);

    // P5: LD, LD via pointer, MUL, SHR, MOV, HLT
    clear8();
    img8[0] = 8'hA4;
    img8[1] = 8'hA9;
    img8[2] = 8'h86;
    img8[3] = 8'hCE;
    img8[4] = 8'h03;
    img8[5] = 8'h44;
    img8[8'hA4] = 8'h03;
    q8.push_back(mk_halt(16'h06, 3'b001, 16'h01, 16'hEC, 16'h03, 16'h01, 16'd19));
    load_reset8();
    wait_halt8("p5_halt_timeout", 100);

    // 16-bit PA: loads, JMP 0x3C05 -> 005, ADD FFFF+0001, HLT
    clear16();
    img16[0] = 16'h01A4;
    img16[1] = 16'h00A9;
    img16[2] = 16'h00AE;
    img16[3] = 16'h0040;
    img16[4] = 16'h3C05;
    img16[5] = 16'h002B;
    img16[6] = 16'h0044;
    img16[10'h1A3] = 16'h8000;
    img16[10'h1A4] = 16'hFFFF;
    img16[10'h3FF] = 16'h0001;
    q16.push_back(mk_halt(16'h007, 3'b011, 16'h0000, 16'h01A4, 16'h0000, 16'h0001, 16'd21));
    load_reset16();
    wait_halt16("pa_halt_timeout", 200);

    // 16-bit PB: continues with SUB, LD 8000, SHL -> 0000 C=1
    img16[6] = 16'h0067;
    img16[7] = 16'h00A1;
    img16[8] = 16'h00E0;
    img16[9] = 16'h0044;
    q16.push_back(mk_halt(16'h00A, 3'b011, 16'h0000, 16'h01A3, 16'h0000, 16'h0001, 16'd31));
    load_reset16();
    wait_halt16("pb_halt_timeout", 200);

    chk("q8_leftover", q8.size(), 0);
    chk("q16_leftover", q16.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
